// File: rtl/pipe_phy_cmd_responder_if.sv
// MAC <-> PHY PIPE command/status bundle. The MAC drives requests and the PHY
// answers with status. master = MAC side, slave = PHY side.
interface pipe_phy_cmd_responder_if #(
  parameter int LANESNUMBER = 16
);
  logic [3:0]               PowerDown;
  logic [3:0]               Rate;
  logic [LANESNUMBER-1:0]   TxDetectRx_Loopback;
  logic [LANESNUMBER-1:0]   TxElecIdle;
  logic                     PclkChangeAck;
  logic                     PhyStatus;
  logic [3*LANESNUMBER-1:0] RxStatus;
  logic                     PclkChangeOk;
  logic [3:0]               CurPowerDown;
  logic [3:0]               CurRate;
  logic                     Busy;

  modport master (
    output PowerDown, Rate, TxDetectRx_Loopback, TxElecIdle, PclkChangeAck,
    input  PhyStatus, RxStatus, PclkChangeOk, CurPowerDown, CurRate, Busy
  );

  modport slave (
    input  PowerDown, Rate, TxDetectRx_Loopback, TxElecIdle, PclkChangeAck,
    output PhyStatus, RxStatus, PclkChangeOk, CurPowerDown, CurRate, Busy
  );
endinterface

// File: rtl/pipe_phy_cmd_responder.sv
// PHY-side PIPE command responder: acknowledges PowerDown, Rate and receiver
// detect requests from the MAC with PhyStatus/RxStatus/PclkChangeOk timing.
module pipe_phy_cmd_responder #(
  parameter int                     LANESNUMBER    = 16,
  parameter int                     PD_LATENCY     = 8,
  parameter int                     RATE_LATENCY   = 32,
  parameter int                     DETECT_LATENCY = 16,
  parameter logic [LANESNUMBER-1:0] RX_PRESENT     = {LANESNUMBER{1'b1}}
) (
  input  logic                          CLK,
  input  logic                          reset,
  pipe_phy_cmd_responder_if.slave       pipe,
  output logic [2:0]                    DbgState
);

  localparam int MAX_LAT_A = (PD_LATENCY > RATE_LATENCY) ? PD_LATENCY : RATE_LATENCY;
  localparam int MAX_LAT   = (MAX_LAT_A > DETECT_LATENCY) ? MAX_LAT_A : DETECT_LATENCY;
  localparam int CNT_W     = $clog2(MAX_LAT) + 1;

  localparam logic [CNT_W-1:0] PD_LAST     = CNT_W'(PD_LATENCY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST   = CNT_W'(RATE_LATENCY - 1);
  localparam logic [CNT_W-1:0] DETECT_LAST = CNT_W'(DETECT_LATENCY - 1);

  typedef enum logic [2:0] {
    RST       = 3'd0,
    IDLE      = 3'd1,
    PD_WAIT   = 3'd2,
    RATE_WAIT = 3'd3,
    RATE_ACK  = 3'd4,
    DETECT    = 3'd5
  } state_t;

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic                     phyStatusQ;
  logic [3*LANESNUMBER-1:0] rxStatusQ;
  logic                     pclkOkQ;
  logic [3:0]               curPd;
  logic [3:0]               curRate;
  logic [3:0]               targetPd;
  logic [3:0]               targetRate;
  logic [3*LANESNUMBER-1:0] detectResult;

  logic pdMismatch;
  logic rateMismatch;
  logic detectReq;

  // Detect answer per lane: 3'b011 where a far-end receiver is present.
  for (genvar i = 0; i < LANESNUMBER; i++) begin : g_detect
    assign detectResult[3*i +: 3] = RX_PRESENT[i] ? 3'b011 : 3'b000;
  end

  assign pdMismatch   = (pipe.PowerDown != curPd);
  assign rateMismatch = (pipe.Rate != curRate) && (curPd == 4'd0);
  assign detectReq    = (|pipe.TxDetectRx_Loopback) && (&pipe.TxElecIdle) &&
                        (curPd == 4'd2);

  // PCLK handshake: PclkChangeOk rises after the rate latency and stays high
  // until PclkChangeAck is sampled high on a rising edge; the edge that samples
  // Ack drops Ok, pulses PhyStatus and commits CurRate together.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state      <= RST;
      cnt        <= '0;
      phyStatusQ <= 1'b1;
      rxStatusQ  <= '0;
      pclkOkQ    <= 1'b0;
      curPd      <= 4'd2;
      curRate    <= 4'd0;
      targetPd   <= 4'd2;
      targetRate <= 4'd0;
    end else begin
      phyStatusQ <= 1'b0;
      rxStatusQ  <= '0;
      case (state)
        RST: begin
          if (cnt == PD_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt        <= cnt + 1'b1;
            phyStatusQ <= 1'b1;
          end
        end
        IDLE: begin
          cnt <= '0;
          if (pdMismatch) begin
            state    <= PD_WAIT;
            targetPd <= pipe.PowerDown;
          end else if (rateMismatch) begin
            state      <= RATE_WAIT;
            targetRate <= pipe.Rate;
          end else if (detectReq) begin
            state <= DETECT;
          end
        end
        PD_WAIT: begin
          if (cnt == PD_LAST) begin
            phyStatusQ <= 1'b1;
            curPd      <= targetPd;
            state      <= IDLE;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RATE_WAIT: begin
          if (cnt == RATE_LAST) begin
            pclkOkQ <= 1'b1;
            state   <= RATE_ACK;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RATE_ACK: begin
          if (pipe.PclkChangeAck) begin
            pclkOkQ    <= 1'b0;
            phyStatusQ <= 1'b1;
            curRate    <= targetRate;
            state      <= IDLE;
            cnt        <= '0;
          end
        end
        DETECT: begin
          if (cnt == DETECT_LAST) begin
            phyStatusQ <= 1'b1;
            rxStatusQ  <= detectResult;
            state      <= IDLE;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= RST;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign pipe.PhyStatus    = phyStatusQ;
  assign pipe.RxStatus     = rxStatusQ;
  assign pipe.PclkChangeOk = pclkOkQ;
  assign pipe.CurPowerDown = curPd;
  assign pipe.CurRate      = curRate;
  assign pipe.Busy         = (state != IDLE);
  assign DbgState          = state;

endmodule

// File: tb/tb_pipe_phy_cmd_responder.sv
// Directed bench for pipe_phy_cmd_responder: reset hold, PowerDown, rate
// handshake, receiver detect, pending rate and reset abort.
module tb_pipe_phy_cmd_responder;

  localparam int LANES = 16;

  logic       CLK;
  logic       reset;
  logic [2:0] DbgState;

  int n_checks;
  int n_bad;

  logic [47:0] exp_q[$];

  pipe_phy_cmd_responder_if #(.LANESNUMBER(LANES)) pipe ();

  pipe_phy_cmd_responder #(
    .LANESNUMBER   (LANES),
    .PD_LATENCY    (8),
    .RATE_LATENCY  (32),
    .DETECT_LATENCY(16),
    .RX_PRESENT    (16'h00FF)
  ) dut (
    .CLK     (CLK),
    .reset   (reset),
    .pipe    (pipe),
    .DbgState(DbgState)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [47:0] exp_rx;
    n_checks = 0;
    n_bad    = 0;

    reset                    = 1'b1;
    pipe.PowerDown           = 4'd2;
    pipe.Rate                = 4'd0;
    pipe.TxDetectRx_Loopback = '0;
    pipe.TxElecIdle          = '0;
    pipe.PclkChangeAck       = 1'b0;
    repeat (3) step();

    // reset values
    check("rst_phystatus", pipe.PhyStatus, 1);
    check("rst_rxstatus", pipe.RxStatus, 0);
    check("rst_pclkok", pipe.PclkChangeOk, 0);
    check("rst_curpd", pipe.CurPowerDown, 2);
    check("rst_currate", pipe.CurRate, 0);
    check("rst_busy", pipe.Busy, 1);
    check("rst_state", DbgState, 0);

    // PhyStatus held for 8 cycles after release, low as IDLE is entered
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("rst_hold_phy", pipe.PhyStatus, (k < 8) ? 1 : 0);
    end
    check("idle_busy", pipe.Busy, 0);
    check("idle_state", DbgState, 1);
    check("idle_curpd", pipe.CurPowerDown, 2);

    // PowerDown P1 -> P0
    pipe.PowerDown = 4'd0;
    for (int k = 1; k <= 9; k++) begin
      step();
      check("pd_phy", pipe.PhyStatus, (k == 9) ? 1 : 0);
      check("pd_curpd", pipe.CurPowerDown, (k == 9) ? 0 : 2);
    end
    step();
    check("pd_pulse_end", pipe.PhyStatus, 0);

    // Rate 0 -> 1 with Ack held off for 50 cycles
    pipe.Rate = 4'd1;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (k == 32) check("rate_ok_early", pipe.PclkChangeOk, 0);
      if (k == 33) check("rate_ok_rise", pipe.PclkChangeOk, 1);
    end
    check("rate_ok_hold", pipe.PclkChangeOk, 1);
    check("rate_hold_state", DbgState, 4);
    check("rate_hold_currate", pipe.CurRate, 0);
    pipe.PclkChangeAck = 1'b1;
    step();
    pipe.PclkChangeAck = 1'b0;
    check("rate_ack_ok", pipe.PclkChangeOk, 0);
    check("rate_ack_phy", pipe.PhyStatus, 1);
    check("rate_ack_currate", pipe.CurRate, 1);
    check("rate_ack_busy", pipe.Busy, 0);
    step();
    check("rate_pulse_end", pipe.PhyStatus, 0);

    // back to P1 for detect
    pipe.PowerDown = 4'd2;
    repeat (9) step();
    check("p1_curpd", pipe.CurPowerDown, 2);
    check("p1_phy", pipe.PhyStatus, 1);

    // detect on lane 0; lanes 0-7 present
    pipe.TxElecIdle          = '1;
    pipe.TxDetectRx_Loopback = 16'h0001;
    exp_rx = 48'h0000_006D_B6DB;
    for (int k = 1; k <= 18; k++) exp_q.push_back((k == 17) ? exp_rx : 48'h0);
    for (int k = 1; k <= 18; k++) begin
      step();
      check("det_rxstatus", pipe.RxStatus, exp_q.pop_front());
      if (k == 16) check("det_phy_early", pipe.PhyStatus, 0);
      if (k == 17) begin
        check("det_phy", pipe.PhyStatus, 1);
        pipe.TxDetectRx_Loopback = '0;
      end
    end
    check("det_done_busy", pipe.Busy, 0);

    // rate request while in P1 stays pending
    pipe.Rate = 4'd2;
    for (int k = 1; k <= 10; k++) begin
      step();
      check("pend_busy", pipe.Busy, 0);
    end
    check("pend_currate", pipe.CurRate, 1);

    // reaching P0 releases the pending rate change
    pipe.PowerDown = 4'd0;
    repeat (9) step();
    check("pend_pd_phy", pipe.PhyStatus, 1);
    check("pend_pd_curpd", pipe.CurPowerDown, 0);
    for (int j = 1; j <= 33; j++) begin
      step();
      if (j == 1)  check("pend_rate_start", DbgState, 3);
      if (j == 32) check("pend_ok_early", pipe.PclkChangeOk, 0);
      if (j == 33) check("pend_ok_rise", pipe.PclkChangeOk, 1);
    end
    repeat (2) step();

    // reset in RATE_ACK aborts immediately
    reset = 1'b1;
    #1;
    check("abort_ok", pipe.PclkChangeOk, 0);
    check("abort_phy", pipe.PhyStatus, 1);
    check("abort_currate", pipe.CurRate, 0);
    check("abort_state", DbgState, 0);
    check("abort_curpd", pipe.CurPowerDown, 2);
    step();
    reset = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
